// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Avalon-MM slave between several masters.
// Grants are held across streams; a pending-read ID FIFO steers read beats back to their issuer.
module sdram_arbiter #(
  parameter int unsigned Masters      = 4,
  parameter int unsigned AddressWidth = 25,
  parameter int unsigned DataWidth    = 16,
  parameter int unsigned MaxPending   = 8,
  parameter int unsigned MaxGrant     = 16
) (
  input  logic                            ipClk,
  input  logic                            Reset,
  input  logic [Masters*AddressWidth-1:0] ipAddress,
  input  logic [Masters*DataWidth/8-1:0]  ipByteEnable,
  input  logic [Masters*DataWidth-1:0]    ipWriteData,
  input  logic [Masters-1:0]              ipWrite,
  input  logic [Masters-1:0]              ipRead,
  output logic [Masters-1:0]              opWaitRequest,
  output logic [DataWidth-1:0]            opReadData,
  output logic [Masters-1:0]              opReadDataValid,
  output logic                            opError,
  output logic [AddressWidth-1:0]         opAddress,
  output logic [DataWidth/8-1:0]          opByteEnable,
  output logic [DataWidth-1:0]            opWriteData,
  output logic                            opWrite,
  output logic                            opRead,
  input  logic                            ipWaitRequest,
  input  logic [DataWidth-1:0]            ipReadData,
  input  logic                            ipReadDataValid
);
  localparam int unsigned IdWidth  = $clog2(Masters);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = $clog2(MaxPending);
  localparam int unsigned PendW    = PtrWidth + 1;
  localparam int unsigned CntWidth = $clog2(MaxGrant) + 1;

  localparam logic [0:0] Idle    = 1'b0;
  localparam logic [0:0] Granted = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IdWidth-1:0]   owner_q, owner_d;
  logic [IdWidth-1:0]   last_q, last_d;
  logic [CntWidth-1:0]  gcnt_q, gcnt_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PendW-1:0]     pending_q, pending_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [Masters-1:0]   rvalid_q, rvalid_d;
  logic                 error_q, error_d;
  logic [IdWidth-1:0]   fifo_q [MaxPending];

  logic [Masters-1:0]   req;
  logic [IdWidth-1:0]   cand;
  logic [IdWidth-1:0]   pick;
  logic                 found;
  logic                 own_rd, own_wr;
  logic                 full, accept, push, pop;

  assign full = (pending_q == PendW'(MaxPending));

  // Route the current owner's request signals downstream.
  always_comb begin
    own_rd       = 1'b0;
    own_wr       = 1'b0;
    opAddress    = '0;
    opByteEnable = '0;
    opWriteData  = '0;
    for (int unsigned i = 0; i < Masters; i++) begin
      if (owner_q == IdWidth'(i)) begin
        own_rd       = ipRead[i];
        own_wr       = ipWrite[i];
        opAddress    = ipAddress[i*AddressWidth +: AddressWidth];
        opByteEnable = ipByteEnable[i*BeWidth +: BeWidth];
        opWriteData  = ipWriteData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Round-robin search starting just after the last owner.
  always_comb begin
    req   = ipRead | ipWrite;
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= Masters; k++) begin
      cand = IdWidth'((32'(last_q) + k) % Masters);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    gcnt_d        = gcnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pending_d     = pending_q;
    rdata_d       = rdata_q;
    rvalid_d      = '0;
    error_d       = error_q;
    opRead        = 1'b0;
    opWrite       = 1'b0;
    opWaitRequest = '1;
    accept        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    case (state_q)
      Idle: begin
        if (found) begin
          owner_d = pick;
          gcnt_d  = '0;
          state_d = Granted;
        end
      end
      Granted: begin
        opRead                 = own_rd & ~full;
        opWrite                = own_wr;
        opWaitRequest[owner_q] = ipWaitRequest | (own_rd & full);
        accept                 = (opRead | opWrite) & ~ipWaitRequest;
        push                   = accept & opRead;
        if (accept) gcnt_d = gcnt_q + CntWidth'(1);
        // The accepted transfer in the release cycle still completes.
        if (!(own_rd | own_wr) || (accept && gcnt_q == CntWidth'(MaxGrant - 1))) begin
          state_d = Idle;
          last_d  = owner_q;
        end
      end
      default: state_d = Idle;
    endcase

    pop = ipReadDataValid & (pending_q != '0);
    if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      rvalid_d = Masters'(1) << fifo_q[rd_ptr_q];
      rdata_d  = ipReadData;
    end else if (ipReadDataValid) begin
      error_d = 1'b1;
    end
    if (push && !pop)      pending_d = pending_q + PendW'(1);
    else if (!push && pop) pending_d = pending_q - PendW'(1);
  end

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state_q   <= Idle;
      owner_q   <= '0;
      last_q    <= IdWidth'(Masters - 1);
      gcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gcnt_q    <= gcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      error_q   <= error_d;
    end
  end

  // Entries are only read while counted as pending, so storage needs no reset.
  always_ff @(posedge ipClk) begin
    if (push) fifo_q[wr_ptr_q] <= owner_q;
  end

  assign opReadData      = rdata_q;
  assign opReadDataValid = rvalid_q;
  assign opError         = error_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: per-cycle vector tables plus a read-return scoreboard.
module tb_sdram_arbiter;
  localparam int M  = 4;
  localparam int AW = 25;
  localparam int DW = 16;

  logic            ipClk;
  logic            Reset;
  logic [M*AW-1:0] ipAddress;
  logic [M*2-1:0]  ipByteEnable;
  logic [M*DW-1:0] ipWriteData;
  logic [M-1:0]    ipWrite, ipRead;
  logic [M-1:0]    opWaitRequest;
  logic [DW-1:0]   opReadData;
  logic [M-1:0]    opReadDataValid;
  logic            opError;
  logic [AW-1:0]   opAddress;
  logic [1:0]      opByteEnable;
  logic [DW-1:0]   opWriteData;
  logic            opWrite, opRead;
  logic            ipWaitRequest;
  logic [DW-1:0]   ipReadData;
  logic            ipReadDataValid;

  sdram_arbiter dut (
    .ipClk(ipClk), .Reset(Reset),
    .ipAddress(ipAddress), .ipByteEnable(ipByteEnable), .ipWriteData(ipWriteData),
    .ipWrite(ipWrite), .ipRead(ipRead),
    .opWaitRequest(opWaitRequest), .opReadData(opReadData),
    .opReadDataValid(opReadDataValid), .opError(opError),
    .opAddress(opAddress), .opByteEnable(opByteEnable), .opWriteData(opWriteData),
    .opWrite(opWrite), .opRead(opRead),
    .ipWaitRequest(ipWaitRequest), .ipReadData(ipReadData), .ipReadDataValid(ipReadDataValid)
  );

  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        wt;
    logic        rv;
    logic [15:0] rdat;
    logic [1:0]  own;
    logic [3:0]  wreq;
    logic        ord;
    logic        owr;
  } vec_t;

  vec_t        vq[$];
  logic [1:0]  issued[$];
  logic [3:0]  exp_rv;
  logic [15:0] exp_rdat;
  logic        exp_err;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h0001232 + i);
  endfunction
  function automatic logic [1:0] be_of(input int i);
    return (i % 2 == 0) ? 2'b11 : 2'b01;
  endfunction
  function automatic logic [DW-1:0] wd_of(input int i);
    return DW'(32'hA000 + i * 32'h0111);
  endfunction

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic wt,
                              input logic rv, input logic [15:0] rdat, input logic [1:0] own,
                              input logic [3:0] wreq, input logic ord, input logic owr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.wt = wt; v.rv = rv; v.rdat = rdat;
    v.own = own; v.wreq = wreq; v.ord = ord; v.owr = owr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the return model.
  task automatic step(input vec_t v);
    logic [1:0] id;
    ipRead = v.rd; ipWrite = v.wr; ipWaitRequest = v.wt;
    ipReadDataValid = v.rv; ipReadData = v.rdat;
    @(negedge ipClk);
    chk("waitrequest", 32'(opWaitRequest), 32'(v.wreq));
    chk("opRead", 32'(opRead), 32'(v.ord));
    chk("opWrite", 32'(opWrite), 32'(v.owr));
    if (v.ord || v.owr) begin
      chk("opAddress", 32'(opAddress), 32'(addr_of(int'(v.own))));
      chk("opByteEnable", 32'(opByteEnable), 32'(be_of(int'(v.own))));
    end
    if (v.owr) chk("opWriteData", 32'(opWriteData), 32'(wd_of(int'(v.own))));
    chk("readdatavalid", 32'(opReadDataValid), 32'(exp_rv));
    if (exp_rv != 4'd0) chk("readdata", 32'(opReadData), 32'(exp_rdat));
    chk("error", 32'(opError), 32'(exp_err));
    exp_rv = 4'd0;
    if (v.rv) begin
      if (issued.size() != 0) begin
        id = issued.pop_front();
        exp_rv = 4'b0001 << id;
        exp_rdat = v.rdat;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (v.ord && !v.wt) issued.push_back(v.own);
    @(posedge ipClk); #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) step(vq[i]);
    vq.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1; ipRead = '0; ipWrite = '0; ipWaitRequest = 1'b0; ipReadDataValid = 1'b0;
    repeat (2) @(posedge ipClk);
    #1 Reset = 1'b0;
    issued.delete(); exp_rv = 4'd0; exp_err = 1'b0;
    @(negedge ipClk);
    chk("rst waitrequest", 32'(opWaitRequest), 32'hF);
    chk("rst opRead", 32'(opRead), 32'h0);
    chk("rst opWrite", 32'(opWrite), 32'h0);
    chk("rst readdatavalid", 32'(opReadDataValid), 32'h0);
    chk("rst readdata", 32'(opReadData), 32'h0);
    chk("rst error", 32'(opError), 32'h0);
    @(posedge ipClk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    ipReadData = '0;
    for (int i = 0; i < M; i++) begin
      ipAddress[i*AW +: AW]  = addr_of(i);
      ipByteEnable[i*2 +: 2] = be_of(i);
      ipWriteData[i*DW +: DW] = wd_of(i);
    end
    exp_rv = 4'd0; exp_rdat = '0; exp_err = 1'b0;
    do_reset();

    // Single read by master 2, data back 3 cycles after accept.
    vq.push_back(mk(4'b0100, 0, 0, 0, 0,        2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0,        2, 4'b1011, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0,        2, 4'b1011, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0,        2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 1, 16'hBEEF, 2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0,        2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0,        2, 4'hF,    0, 0));
    run_table();

    // Master 0 issues 3 reads, master 1 issues 2, all returned late and in order.
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 4'hF,    0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 4'b1110, 1, 0));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 4'b1110, 0, 0));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'hF,    0, 0));
    for (int i = 0; i < 2; i++) vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 4'b1101, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 4'b1101, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 0, 0, 1, 16'(16'h1000 + i), 0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0));
    run_table();

    // Master 3 fills the pending FIFO; ninth read waits for a return, then pushes while popping.
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 4'hF, 0, 0));
    for (int i = 0; i < 8; i++) vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 4'b0111, 1, 0));
    for (int i = 0; i < 2; i++) vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 4'hF, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 1, 16'h3000, 3, 4'hF,    0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 1, 16'h3001, 3, 4'b0111, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0,        3, 4'b0111, 0, 0));
    for (int i = 0; i < 7; i++) vq.push_back(mk(0, 0, 0, 1, 16'(16'h3002 + i), 0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0));
    run_table();

    // Master 1 write stalled 5 cycles, then early release; master 2 follows with a read.
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 1, 4'hF, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 4'b0010, 1, 0, 0, 1, 4'hF, 0, 1));
    vq.push_back(mk(4'b0000, 4'b0010, 0, 0, 0,        1, 4'b1101, 0, 1));
    vq.push_back(mk(4'b0100, 4'b0000, 0, 0, 0,        1, 4'b1101, 0, 0));
    vq.push_back(mk(4'b0100, 4'b0000, 0, 0, 0,        2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0100, 4'b0000, 0, 0, 0,        2, 4'b1011, 1, 0));
    vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 0,        2, 4'b1011, 0, 0));
    vq.push_back(mk(4'b0000, 4'b0000, 0, 1, 16'hCAFE, 2, 4'hF,    0, 0));
    vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 0,        2, 4'hF,    0, 0));
    run_table();

    // All masters write continuously: grants 0,1,2,3,0 of 16 accepts, one idle cycle apart.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step(mk(0, 4'hF, 0, 0, 0, 2'(g % 4), 4'hF, 0, 0));
      for (int j = 0; j < 16; j++)
        step(mk(0, 4'hF, 0, 0, 0, 2'(g % 4), ~(4'b0001 << (g % 4)), 0, 1));
    end
    step(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0));

    // Stray beat sets the sticky error; reset with two reads outstanding clears everything.
    vq.push_back(mk(0, 0, 0, 1, 16'hDEAD, 0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 4'hF, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 0));
    for (int i = 0; i < 2; i++) vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 4'b1110, 1, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 4'b1110, 0, 0));
    run_table();
    do_reset();
    vq.push_back(mk(0, 0, 0, 1, 16'h5555, 0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 4'hF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,        0, 4'hF, 0, 0));
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single Avalon-MM slave port of the SDRAM controller between `Masters` Avalon-MM requesters. It holds a grant across consecutive transfers so that streaming masters keep the controller's open-row fast path. A pending-read ID FIFO routes each pipelined `readdatavalid` beat back to the master that issued it. The block sits between the system interconnect and the SDRAM controller, on the same `ipClk` domain.

## Interface
- `Masters`, 4, number of requesters (2..8); `IdWidth = $clog2(Masters)`.
- `AddressWidth`, 25, word address width.
- `DataWidth`, 16, data width; byte-enable width `DataWidth/8`.
- `MaxPending`, 8, depth of the pending-read FIFO (power of 2).
- `MaxGrant`, 16, maximum accepted transfers per grant.
- `ipClk`  in  1  clock.
- `Reset`  in  1  synchronous, active-high reset (reset `Reset`, synchronous, active-high; clock `ipClk`).
- `ipAddress`  in  Masters*AddressWidth  per-master address; master i occupies slice i.
- `ipByteEnable`  in  Masters*DataWidth/8  per-master byte enables.
- `ipWriteData`  in  Masters*DataWidth  per-master write data.
- `ipWrite`, `ipRead`  in  Masters  per-master requests.
- `opWaitRequest`  out  Masters  per-master stall.
- `opReadData`  out  DataWidth  read data, broadcast to all masters.
- `opReadDataValid`  out  Masters  per-master read-data strobe, one-hot or zero.
- `opError`  out  1  sticky flag: read data arrived while no read was pending.
- `opAddress`, `opByteEnable`, `opWriteData`, `opWrite`, `opRead`  out  —  downstream request to the controller.
- `ipWaitRequest`, `ipReadData`, `ipReadDataValid`  in  —  downstream response from the controller.

## Operation
- The state machine has two states, `Idle` and `Granted`. Registers: `Owner` (IdWidth), `Last` (IdWidth), `GrantCount`, and the FIFO with its `Pending` count (0..MaxPending).
- **Idle**
  - Downstream `opRead` and `opWrite` are 0. All `opWaitRequest` bits are 1.
  - If any master has `ipRead|ipWrite` set, grant the first requester found searching from `Last+1` with wrap-around. Then `Owner` <= that master, `GrantCount` <= 0, next state `Granted`.
- **Granted**
  - The downstream request is a combinational mux of `Owner`'s signals.
  - `opRead = ipRead[Owner] & (Pending != MaxPending)`.
  - `opWrite = ipWrite[Owner]`.
  - `opWaitRequest[Owner] = ipWaitRequest | (ipRead[Owner] & Pending == MaxPending)`. All other `opWaitRequest` bits are 1.
- **Accept.** A transfer is accepted when `(opRead|opWrite) & ~ipWaitRequest`. Each accept increments `GrantCount`. An accepted read pushes `Owner` into the FIFO.
- **Release** (go to `Idle`, `Last <= Owner`) when either:
  - `Owner` has neither read nor write asserted in a cycle, or
  - an accept occurs with `GrantCount == MaxGrant-1`.

  The release cycle's own accepted transfer is still valid.
- **Return path.** On `ipReadDataValid`:
  - pop the FIFO head `H`;
  - next cycle `opReadData <= ipReadData` and `opReadDataValid <= 1<<H`.
- **Simultaneous push and pop:** `Pending` is unchanged; the push writes and the pop reads the correct entries.
- **`ipReadDataValid` with `Pending == 0`:** no pop, `opReadDataValid` stays 0, `opError <= 1`. `opError` is cleared only by `Reset`.
- **Writes** never touch the FIFO. A full FIFO stalls only reads.
- **Reset values:**
  - state `Idle`, `Last = Masters-1` (so master 0 wins first);
  - `Owner = 0`, `GrantCount = 0`, FIFO empty, `Pending = 0`;
  - `opWaitRequest` all 1, `opReadDataValid = 0`, `opReadData = 0`, `opError = 0`;
  - downstream `opRead = opWrite = 0`.
- **Reset mid-operation:** reads still outstanding are discarded. Their returning beats after reset set `opError`. Integrators must reset the arbiter and the controller together.

## Timing
- Arbitration latency is 1 cycle. A request first seen in `Idle` at cycle n reaches downstream combinationally in cycle n+1.
- A back-to-back same-master stream adds no bubbles after the grant, except one `Idle` cycle at each release.
- Read return latency: downstream `ipReadDataValid` at cycle m gives `opReadDataValid` at m+1.
- Round-robin fairness: with all masters requesting continuously, each master waits at most `(Masters-1)*(MaxGrant+1)` transfer slots between grants.
- No combinational path from `ipRead`/`ipWrite` of a non-owner to any output.

## Test plan
- **Single read.** Master 2 reads address 0x0001234 while the controller returns data 0xBEEF 3 cycles after accept.
  - Grant 1 cycle after request.
  - Exactly one `opReadDataValid = 4'b0100` carrying 0xBEEF.
- **Contention.** All 4 masters request continuously with `MaxGrant = 16`.
  - Grant order is 0,1,2,3,0.
  - Each grant ends after exactly 16 accepts.
  - One `Idle` cycle between grants.
- **Interleaved returns.** Master 0 issues 3 reads, then master 1 issues 2 reads, and the controller returns all 5 beats late.
  - `opReadDataValid` sequence is 1,1,1,2,2 (one-hot values).
  - Beats are returned in order.
- **FIFO full.** 8 reads are outstanding with no return, and the owner asserts a ninth read.
  - `opRead = 0` and `opWaitRequest[Owner] = 1` until the first return.
  - The ninth read is then accepted in the following cycle.
- **Stall and early release.**
  - With `ipWaitRequest` held high for 5 cycles during a write, the write data and address hold stable and nothing is accepted.
  - The owner then drops its request, and the arbiter returns to `Idle` the next cycle.
- **Error and reset.** Inject `ipReadDataValid` with the FIFO empty, then assert `Reset` while 2 reads are pending.
  - The stray beat sets `opError = 1`, which stays set until `Reset`.
  - After `Reset`: `opError = 0`, `Pending = 0`, `opWaitRequest = 4'hF`.
